// File: rtl/alu_issue.sv
// ID/EX issue stage: decodes a MIPS instruction word into an ALU request, forwards operands
// from EX/MEM and MEM/WB, and registers the request for the EX-stage alu.
module alu_issue #(
    parameter int DW     = 32,
    parameter int RW     = 5,
    parameter int FWD_EN = 1
) (
    input  logic          clk_87,
    input  logic          rst_n_87,
    input  logic          flush_87,
    input  logic          in_valid_87,
    output logic          in_ready_87,
    input  logic [31:0]   instr_87,
    input  logic [DW-1:0] rs_data_87,
    input  logic [DW-1:0] rt_data_87,
    input  logic          exmem_wr_87,
    input  logic [RW-1:0] exmem_rd_87,
    input  logic [DW-1:0] exmem_data_87,
    input  logic          memwb_wr_87,
    input  logic [RW-1:0] memwb_rd_87,
    input  logic [DW-1:0] memwb_data_87,
    output logic          out_valid_87,
    input  logic          out_ready_87,
    output logic [DW-1:0] arg_a_87,
    output logic [DW-1:0] arg_b_87,
    output logic [3:0]    alu_op_87,
    output logic [RW-1:0] dest_87,
    output logic          reg_write_87,
    output logic          mem_read_87,
    output logic          mem_write_87,
    output logic          branch_87,
    output logic          illegal_87
);

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_ADDU  = 4'h1;
    localparam logic [3:0] ALU_SUB   = 4'h2;
    localparam logic [3:0] ALU_SUBU  = 4'h3;
    localparam logic [3:0] ALU_AND   = 4'h4;
    localparam logic [3:0] ALU_OR    = 4'h5;
    localparam logic [3:0] ALU_SLT   = 4'h6;
    localparam logic [3:0] ALU_SLTU  = 4'h7;
    localparam logic [3:0] ALU_MULT  = 4'h8;
    localparam logic [3:0] ALU_MULTU = 4'h9;
    localparam logic [3:0] ALU_DIV   = 4'hA;
    localparam logic [3:0] ALU_DIVU  = 4'hB;
    localparam logic [3:0] ALU_SLL   = 4'hC;
    localparam logic [3:0] ALU_SRL   = 4'hD;

    logic [5:0]    opc, funct;
    logic [RW-1:0] rs_a, rt_a, rd_a;
    logic [DW-1:0] sext_imm, zext_imm, shamt;

    assign opc      = instr_87[31:26];
    assign funct    = instr_87[5:0];
    assign rs_a     = RW'(instr_87[25:21]);
    assign rt_a     = RW'(instr_87[20:16]);
    assign rd_a     = RW'(instr_87[15:11]);
    assign sext_imm = {{(DW-16){instr_87[15]}}, instr_87[15:0]};
    assign zext_imm = {{(DW-16){1'b0}}, instr_87[15:0]};
    assign shamt    = {{(DW-5){1'b0}}, instr_87[10:6]};

    // EX/MEM has priority over MEM/WB because it holds the younger result.
    logic [DW-1:0] rs_val, rt_val;
    always_comb begin
        rs_val = rs_data_87;
        rt_val = rt_data_87;
        if (FWD_EN != 0) begin
            if (exmem_wr_87 && exmem_rd_87 != '0 && exmem_rd_87 == rs_a)
                rs_val = exmem_data_87;
            else if (memwb_wr_87 && memwb_rd_87 != '0 && memwb_rd_87 == rs_a)
                rs_val = memwb_data_87;
            if (exmem_wr_87 && exmem_rd_87 != '0 && exmem_rd_87 == rt_a)
                rt_val = exmem_data_87;
            else if (memwb_wr_87 && memwb_rd_87 != '0 && memwb_rd_87 == rt_a)
                rt_val = memwb_data_87;
        end
    end

    logic [3:0]    d_op;
    logic [DW-1:0] d_a, d_b;
    logic [RW-1:0] d_dest;
    logic          d_rw, d_mr, d_mw, d_br, d_ill, rt_used;

    always_comb begin
        d_op    = ALU_ADDU;
        d_a     = rs_val;
        d_b     = rt_val;
        d_dest  = rt_a;
        d_rw    = 1'b0;
        d_mr    = 1'b0;
        d_mw    = 1'b0;
        d_br    = 1'b0;
        d_ill   = 1'b0;
        rt_used = 1'b0;
        case (opc)
            6'h00: begin
                d_dest  = rd_a;
                rt_used = 1'b1;
                d_rw    = 1'b1;
                case (funct)
                    6'h20: d_op = ALU_ADD;
                    6'h21: d_op = ALU_ADDU;
                    6'h22: d_op = ALU_SUB;
                    6'h23: d_op = ALU_SUBU;
                    6'h24: d_op = ALU_AND;
                    6'h25: d_op = ALU_OR;
                    6'h2A: d_op = ALU_SLT;
                    6'h2B: d_op = ALU_SLTU;
                    6'h18: begin d_op = ALU_MULT;  d_rw = 1'b0; end
                    6'h19: begin d_op = ALU_MULTU; d_rw = 1'b0; end
                    6'h1A: begin d_op = ALU_DIV;   d_rw = 1'b0; end
                    6'h1B: begin d_op = ALU_DIVU;  d_rw = 1'b0; end
                    6'h00: begin d_op = ALU_SLL; d_a = rt_val; d_b = shamt; end
                    6'h02: begin d_op = ALU_SRL; d_a = rt_val; d_b = shamt; end
                    default: begin d_ill = 1'b1; d_rw = 1'b0; end
                endcase
            end
            6'h08: begin d_op = ALU_ADD;  d_b = sext_imm; d_rw = 1'b1; end
            6'h09: begin d_op = ALU_ADDU; d_b = sext_imm; d_rw = 1'b1; end
            6'h0A: begin d_op = ALU_SLT;  d_b = sext_imm; d_rw = 1'b1; end
            6'h0B: begin d_op = ALU_SLTU; d_b = sext_imm; d_rw = 1'b1; end
            6'h0C: begin d_op = ALU_AND;  d_b = zext_imm; d_rw = 1'b1; end
            6'h0D: begin d_op = ALU_OR;   d_b = zext_imm; d_rw = 1'b1; end
            6'h23: begin d_op = ALU_ADD;  d_b = sext_imm; d_rw = 1'b1; d_mr = 1'b1; end
            6'h2B: begin d_op = ALU_ADD;  d_b = sext_imm; d_mw = 1'b1; rt_used = 1'b1; end
            6'h04: begin d_op = ALU_SUB;  d_br = 1'b1; rt_used = 1'b1; end
            default: d_ill = 1'b1;
        endcase
    end

    // Handshake: a request transfers on any edge where out_valid_87 & out_ready_87; an
    // instruction is taken on any edge where in_valid_87 & in_ready_87. While out_valid_87 is
    // high and out_ready_87 low, every output holds. flush_87 overrides all of it.
    logic advance, load_use;
    assign advance  = !out_valid_87 || out_ready_87;
    assign load_use = out_valid_87 && mem_read_87 && dest_87 != '0 && in_valid_87 &&
                      (dest_87 == rs_a || (dest_87 == rt_a && rt_used));
    assign in_ready_87 = flush_87 || (advance && !load_use);

    always_ff @(posedge clk_87 or negedge rst_n_87) begin
        if (!rst_n_87) begin
            out_valid_87 <= 1'b0;
            arg_a_87     <= '0;
            arg_b_87     <= '0;
            alu_op_87    <= '0;
            dest_87      <= '0;
            reg_write_87 <= 1'b0;
            mem_read_87  <= 1'b0;
            mem_write_87 <= 1'b0;
            branch_87    <= 1'b0;
            illegal_87   <= 1'b0;
        end else if (flush_87) begin
            out_valid_87 <= 1'b0;
        end else if (advance) begin
            if (in_valid_87 && in_ready_87) begin
                out_valid_87 <= 1'b1;
                arg_a_87     <= d_a;
                arg_b_87     <= d_b;
                alu_op_87    <= d_op;
                dest_87      <= d_dest;
                reg_write_87 <= d_rw && d_dest != '0;
                mem_read_87  <= d_mr;
                mem_write_87 <= d_mw;
                branch_87    <= d_br;
                illegal_87   <= d_ill;
            end else begin
                out_valid_87 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode, operand selection, forwarding, load-use stall,
// hold/flush and asynchronous reset, checked against hand-computed values.
module tb_alu_issue;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_ADDU = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h5;
    localparam logic [3:0] ALU_MULT = 4'h8;
    localparam logic [3:0] ALU_SLL  = 4'hC;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, rs_data, rt_data, exmem_data, memwb_data, arg_a, arg_b;
    logic        exmem_wr, memwb_wr;
    logic [4:0]  exmem_rd, memwb_rd, dest;
    logic [3:0]  alu_op;
    logic        reg_write, mem_read, mem_write, branch, illegal;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_issue #(.DW(32), .RW(5), .FWD_EN(1)) dut (
        .clk_87(clk), .rst_n_87(rst_n), .flush_87(flush),
        .in_valid_87(in_valid), .in_ready_87(in_ready), .instr_87(instr),
        .rs_data_87(rs_data), .rt_data_87(rt_data),
        .exmem_wr_87(exmem_wr), .exmem_rd_87(exmem_rd), .exmem_data_87(exmem_data),
        .memwb_wr_87(memwb_wr), .memwb_rd_87(memwb_rd), .memwb_data_87(memwb_data),
        .out_valid_87(out_valid), .out_ready_87(out_ready),
        .arg_a_87(arg_a), .arg_b_87(arg_b), .alu_op_87(alu_op), .dest_87(dest),
        .reg_write_87(reg_write), .mem_read_87(mem_read), .mem_write_87(mem_write),
        .branch_87(branch), .illegal_87(illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
        instr    = i;
        rs_data  = rs;
        rt_data  = rt;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; rs_data = '0; rt_data = '0;
        exmem_wr = 1'b0; exmem_rd = '0; exmem_data = '0;
        memwb_wr = 1'b0; memwb_rd = '0; memwb_data = '0;
        #12;
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_arg_a", arg_a, 32'd0);
        check("rst_op", {28'b0, alu_op}, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // add $3,$1,$2
        issue(32'h00221820, 32'd5, 32'd7);
        check("add_valid", {31'b0, out_valid}, 32'd1);
        check("add_op", {28'b0, alu_op}, {28'b0, ALU_ADD});
        check("add_a", arg_a, 32'd5);
        check("add_b", arg_b, 32'd7);
        check("add_dest", {27'b0, dest}, 32'd3);
        check("add_rw", {31'b0, reg_write}, 32'd1);

        // addi $4,$1,-1
        issue(32'h2024FFFF, 32'd5, 32'd0);
        check("addi_op", {28'b0, alu_op}, {28'b0, ALU_ADD});
        check("addi_b", arg_b, 32'hFFFFFFFF);
        check("addi_dest", {27'b0, dest}, 32'd4);

        // ori $4,$1,0xFFFF
        issue(32'h3424FFFF, 32'd5, 32'd0);
        check("ori_op", {28'b0, alu_op}, {28'b0, ALU_OR});
        check("ori_b", arg_b, 32'h0000FFFF);

        // forwarding priority on rs=$1
        exmem_wr = 1'b1; exmem_rd = 5'd1; exmem_data = 32'd9;
        memwb_wr = 1'b1; memwb_rd = 5'd1; memwb_data = 32'd4;
        issue(32'h00221820, 32'd2, 32'd7);
        check("fwd_exmem_a", arg_a, 32'd9);
        check("fwd_exmem_b", arg_b, 32'd7);
        exmem_rd = 5'd0;
        issue(32'h00221820, 32'd2, 32'd7);
        check("fwd_memwb_a", arg_a, 32'd4);
        exmem_wr = 1'b0; memwb_wr = 1'b0; memwb_rd = 5'd0;

        // sll $2,$3,4
        issue(32'h00031100, 32'd0, 32'h11);
        check("sll_op", {28'b0, alu_op}, {28'b0, ALU_SLL});
        check("sll_a", arg_a, 32'h11);
        check("sll_b", arg_b, 32'd4);

        // lw $5,8($1) then add $6,$5,$5
        issue(32'h8C250008, 32'h100, 32'd0);
        check("lw_a", arg_a, 32'h100);
        check("lw_b", arg_b, 32'd8);
        check("lw_mr", {31'b0, mem_read}, 32'd1);
        check("lw_dest", {27'b0, dest}, 32'd5);
        instr = 32'h00A53020; rs_data = 32'd3; rt_data = 32'd3; in_valid = 1'b1;
        #1;
        check("lu_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        check("lu_bubble", {31'b0, out_valid}, 32'd0);
        check("lu_ready_again", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("lu_add_valid", {31'b0, out_valid}, 32'd1);
        check("lu_add_dest", {27'b0, dest}, 32'd6);
        check("lu_add_mr", {31'b0, mem_read}, 32'd0);

        // sw $2,4($1)
        issue(32'hAC220004, 32'd10, 32'd20);
        check("sw_mw", {31'b0, mem_write}, 32'd1);
        check("sw_rw", {31'b0, reg_write}, 32'd0);
        check("sw_b", arg_b, 32'd4);

        // beq $1,$2
        issue(32'h10220003, 32'd10, 32'd20);
        check("beq_op", {28'b0, alu_op}, {28'b0, ALU_SUB});
        check("beq_br", {31'b0, branch}, 32'd1);
        check("beq_b", arg_b, 32'd20);

        // unlisted opcode
        issue(32'hFC000000, 32'd0, 32'd0);
        check("ill_valid", {31'b0, out_valid}, 32'd1);
        check("ill_flag", {31'b0, illegal}, 32'd1);
        check("ill_op", {28'b0, alu_op}, {28'b0, ALU_ADDU});
        check("ill_rw", {31'b0, reg_write}, 32'd0);

        // add $0,$1,$2 and mult $1,$2
        issue(32'h00220020, 32'd1, 32'd2);
        check("dest0_rw", {31'b0, reg_write}, 32'd0);
        check("dest0_ill", {31'b0, illegal}, 32'd0);
        issue(32'h00220018, 32'd1, 32'd2);
        check("mult_op", {28'b0, alu_op}, {28'b0, ALU_MULT});
        check("mult_rw", {31'b0, reg_write}, 32'd0);

        // sub held under backpressure, then flushed
        issue(32'h00221822, 32'd8, 32'd3);
        out_ready = 1'b0;
        instr = 32'h00221820; in_valid = 1'b1;
        #1;
        check("hold_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        check("hold_valid", {31'b0, out_valid}, 32'd1);
        check("hold_op", {28'b0, alu_op}, {28'b0, ALU_SUB});
        check("hold_a", arg_a, 32'd8);
        flush = 1'b1;
        #1;
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        check("flush_pre_valid", {31'b0, out_valid}, 32'd1);
        check("flush_pre_op", {28'b0, alu_op}, {28'b0, ALU_SUB});
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("flush_valid", {31'b0, out_valid}, 32'd0);

        // asynchronous reset mid-traffic
        issue(32'h2024FFFF, 32'd5, 32'd0);
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'b0, out_valid}, 32'd0);
        check("arst_b", arg_b, 32'd0);
        check("arst_dest", {27'b0, dest}, 32'd0);
        check("arst_rw", {31'b0, reg_write}, 32'd0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_after_valid", {31'b0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
